// File: rtl/pipe_ctrl_chain.sv
// Pipeline register chain for the non-forwarding 5-stage core: PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB control state, hazard-unit stall/flush application and event counters.
module pipe_ctrl_chain #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pc_wren,
    input  logic             i_IFID_wren,
    input  logic             i_IFID_clear,
    input  logic             i_IDEX_clear,
    input  logic             i_EXMEM_clear,
    input  logic [31:0]      i_pc_next,
    input  logic [31:0]      i_instr,
    input  logic             i_id_rdwren,
    input  logic             i_id_is_br,
    input  logic             i_id_is_uncbr,
    input  logic             i_ex_pcsel,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_IFID_pc,
    output logic [31:0]      o_IFID_instr,
    output logic [4:0]       o_IFID_rs1,
    output logic [4:0]       o_IFID_rs2,
    output logic             o_IDEX_valid,
    output logic             o_IDEX_rdwren,
    output logic             o_IDEX_is_br,
    output logic             o_IDEX_is_uncbr,
    output logic [4:0]       o_IDEX_rd,
    output logic             o_EXMEM_valid,
    output logic             o_EXMEM_rdwren,
    output logic             o_EXMEM_pcsel,
    output logic             o_EXMEM_is_br,
    output logic             o_EXMEM_is_uncbr,
    output logic [4:0]       o_EXMEM_rd,
    output logic             o_MEMWB_valid,
    output logic             o_MEMWB_rdwren,
    output logic [4:0]       o_MEMWB_rd,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_retire_cnt
);

    localparam int unsigned   XLEN      = 32;
    localparam int unsigned   REG_W     = 5;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifid_t;

    typedef struct packed {
        logic             valid;
        logic             rdwren;
        logic             is_br;
        logic             is_uncbr;
        logic [REG_W-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic             valid;
        logic             rdwren;
        logic             pcsel;
        logic             is_br;
        logic             is_uncbr;
        logic [REG_W-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic             valid;
        logic             rdwren;
        logic [REG_W-1:0] rd;
    } memwb_t;

    logic [XLEN-1:0]  pc_q,     pc_n;
    ifid_t            ifid_q,   ifid_n;
    idex_t            idex_q,   idex_n;
    exmem_t           exmem_q,  exmem_n;
    memwb_t           memwb_q,  memwb_n;
    logic [CNT_W-1:0] stall_q,  stall_n;
    logic [CNT_W-1:0] flush_q,  flush_n;
    logic [CNT_W-1:0] retire_q, retire_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Next-state for every stage; bubbles zero all flags so they can never raise a hazard or redirect
    always_comb begin
        pc_n     = pc_q;
        ifid_n   = ifid_q;
        idex_n   = '0;
        exmem_n  = '0;
        memwb_n  = '0;
        stall_n  = stall_q;
        flush_n  = flush_q;
        retire_n = retire_q;

        if (i_pc_wren) begin
            pc_n = i_pc_next;
        end

        if (i_IFID_clear) begin
            ifid_n       = '0;
            ifid_n.instr = NOP_INSTR;
        end else if (i_IFID_wren) begin
            ifid_n.valid = 1'b1;
            ifid_n.pc    = pc_q;
            ifid_n.instr = i_instr;
        end

        if (!i_IDEX_clear) begin
            idex_n.valid    = ifid_q.valid;
            idex_n.rd       = ifid_q.instr[11:7];
            idex_n.rdwren   = i_id_rdwren   & ifid_q.valid;
            idex_n.is_br    = i_id_is_br    & ifid_q.valid;
            idex_n.is_uncbr = i_id_is_uncbr & ifid_q.valid;
        end

        if (!i_EXMEM_clear) begin
            exmem_n.valid    = idex_q.valid;
            exmem_n.rdwren   = idex_q.rdwren;
            exmem_n.is_br    = idex_q.is_br;
            exmem_n.is_uncbr = idex_q.is_uncbr;
            exmem_n.rd       = idex_q.rd;
            exmem_n.pcsel    = i_ex_pcsel & idex_q.valid;
        end

        memwb_n.valid  = exmem_q.valid;
        memwb_n.rdwren = exmem_q.rdwren;
        memwb_n.rd     = exmem_q.rd;

        if (!i_pc_wren && !i_IFID_wren) begin
            stall_n = sat_inc(stall_q);
        end
        if (i_EXMEM_clear) begin
            flush_n = sat_inc(flush_q);
        end
        if (memwb_q.valid) begin
            retire_n = sat_inc(retire_q);
        end
    end

    // Reset overrides every control input, including a flush on the same edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q         <= RESET_PC;
            ifid_q.valid <= 1'b0;
            ifid_q.pc    <= '0;
            ifid_q.instr <= NOP_INSTR;
            idex_q       <= '0;
            exmem_q      <= '0;
            memwb_q      <= '0;
            stall_q      <= '0;
            flush_q      <= '0;
            retire_q     <= '0;
        end else begin
            pc_q     <= pc_n;
            ifid_q   <= ifid_n;
            idex_q   <= idex_n;
            exmem_q  <= exmem_n;
            memwb_q  <= memwb_n;
            stall_q  <= stall_n;
            flush_q  <= flush_n;
            retire_q <= retire_n;
        end
    end

    assign o_pc             = pc_q;
    assign o_IFID_pc        = ifid_q.pc;
    assign o_IFID_instr     = ifid_q.instr;
    assign o_IFID_rs1       = ifid_q.instr[19:15];
    assign o_IFID_rs2       = ifid_q.instr[24:20];

    assign o_IDEX_valid     = idex_q.valid;
    assign o_IDEX_rdwren    = idex_q.rdwren;
    assign o_IDEX_is_br     = idex_q.is_br;
    assign o_IDEX_is_uncbr  = idex_q.is_uncbr;
    assign o_IDEX_rd        = idex_q.rd;

    assign o_EXMEM_valid    = exmem_q.valid;
    assign o_EXMEM_rdwren   = exmem_q.rdwren;
    assign o_EXMEM_pcsel    = exmem_q.pcsel;
    assign o_EXMEM_is_br    = exmem_q.is_br;
    assign o_EXMEM_is_uncbr = exmem_q.is_uncbr;
    assign o_EXMEM_rd       = exmem_q.rd;

    assign o_MEMWB_valid    = memwb_q.valid;
    assign o_MEMWB_rdwren   = memwb_q.rdwren;
    assign o_MEMWB_rd       = memwb_q.rd;

    assign o_stall_cnt      = stall_q;
    assign o_flush_cnt      = flush_q;
    assign o_retire_cnt     = retire_q;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Self-checking bench for pipe_ctrl_chain: directed scenarios with literal expectations,
// then randomized controls checked every cycle against a slot-array model of the pipeline.
module tb_pipe_ctrl_chain;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned CW     = 4;
    localparam int          CMAX   = (1 << CW) - 1;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_pc_wren, i_IFID_wren;
    logic          i_IFID_clear, i_IDEX_clear, i_EXMEM_clear;
    logic [31:0]   i_pc_next, i_instr;
    logic          i_id_rdwren, i_id_is_br, i_id_is_uncbr, i_ex_pcsel;
    logic [31:0]   o_pc, o_IFID_pc, o_IFID_instr;
    logic [4:0]    o_IFID_rs1, o_IFID_rs2;
    logic          o_IDEX_valid, o_IDEX_rdwren, o_IDEX_is_br, o_IDEX_is_uncbr;
    logic [4:0]    o_IDEX_rd;
    logic          o_EXMEM_valid, o_EXMEM_rdwren, o_EXMEM_pcsel, o_EXMEM_is_br, o_EXMEM_is_uncbr;
    logic [4:0]    o_EXMEM_rd;
    logic          o_MEMWB_valid, o_MEMWB_rdwren;
    logic [4:0]    o_MEMWB_rd;
    logic [CW-1:0] o_stall_cnt, o_flush_cnt, o_retire_cnt;

    pipe_ctrl_chain #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_pc_wren(i_pc_wren), .i_IFID_wren(i_IFID_wren),
        .i_IFID_clear(i_IFID_clear), .i_IDEX_clear(i_IDEX_clear), .i_EXMEM_clear(i_EXMEM_clear),
        .i_pc_next(i_pc_next), .i_instr(i_instr),
        .i_id_rdwren(i_id_rdwren), .i_id_is_br(i_id_is_br), .i_id_is_uncbr(i_id_is_uncbr),
        .i_ex_pcsel(i_ex_pcsel),
        .o_pc(o_pc), .o_IFID_pc(o_IFID_pc), .o_IFID_instr(o_IFID_instr),
        .o_IFID_rs1(o_IFID_rs1), .o_IFID_rs2(o_IFID_rs2),
        .o_IDEX_valid(o_IDEX_valid), .o_IDEX_rdwren(o_IDEX_rdwren), .o_IDEX_is_br(o_IDEX_is_br),
        .o_IDEX_is_uncbr(o_IDEX_is_uncbr), .o_IDEX_rd(o_IDEX_rd),
        .o_EXMEM_valid(o_EXMEM_valid), .o_EXMEM_rdwren(o_EXMEM_rdwren), .o_EXMEM_pcsel(o_EXMEM_pcsel),
        .o_EXMEM_is_br(o_EXMEM_is_br), .o_EXMEM_is_uncbr(o_EXMEM_is_uncbr), .o_EXMEM_rd(o_EXMEM_rd),
        .o_MEMWB_valid(o_MEMWB_valid), .o_MEMWB_rdwren(o_MEMWB_rdwren), .o_MEMWB_rd(o_MEMWB_rd),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt), .o_retire_cnt(o_retire_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Model: one slot per pipeline register, index 0 = IF/ID ... 3 = MEM/WB
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        rdwren;
        logic        is_br;
        logic        is_uncbr;
        logic        pcsel;
    } slot_t;

    slot_t       m[4];
    logic [31:0] m_pc;
    int          m_stall, m_flush, m_retire;
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    function automatic slot_t bubble();
        slot_t s;
        s = '{valid: 1'b0, pc: 32'h0, instr: 32'h0, rd: 5'h0,
              rdwren: 1'b0, is_br: 1'b0, is_uncbr: 1'b0, pcsel: 1'b0};
        return s;
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge from the inputs currently applied
    task automatic model_update();
        slot_t n[4];
        logic [31:0] ins;
        if (i_rst) begin
            for (int i = 0; i < 4; i++) m[i] = bubble();
            m[0].instr = NOP;
            m_pc = RST_PC;
            m_stall = 0; m_flush = 0; m_retire = 0;
            return;
        end
        if (!i_pc_wren && !i_IFID_wren) m_stall = sat(m_stall);
        if (i_EXMEM_clear)              m_flush = sat(m_flush);
        if (m[3].valid)                 m_retire = sat(m_retire);

        n[3] = bubble();
        n[3].valid = m[2].valid; n[3].rdwren = m[2].rdwren; n[3].rd = m[2].rd;

        n[2] = i_EXMEM_clear ? bubble() : m[1];
        if (!i_EXMEM_clear) n[2].pcsel = i_ex_pcsel && m[1].valid;

        n[1] = bubble();
        if (!i_IDEX_clear) begin
            ins = m[0].instr;
            n[1].valid    = m[0].valid;
            n[1].rd       = ins[11:7];
            n[1].rdwren   = i_id_rdwren   && m[0].valid;
            n[1].is_br    = i_id_is_br    && m[0].valid;
            n[1].is_uncbr = i_id_is_uncbr && m[0].valid;
        end

        if (i_IFID_clear) begin
            n[0] = bubble();
            n[0].instr = NOP;
        end else if (i_IFID_wren) begin
            n[0] = bubble();
            n[0].valid = 1'b1; n[0].pc = m_pc; n[0].instr = i_instr;
        end else begin
            n[0] = m[0];
        end

        if (i_pc_wren) m_pc = i_pc_next;
        for (int i = 0; i < 4; i++) m[i] = n[i];
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_update();
        #1;
    endtask

    task automatic run_defaults();
        i_rst = 1'b0;
        i_pc_wren = 1'b1; i_IFID_wren = 1'b1;
        i_IFID_clear = 1'b0; i_IDEX_clear = 1'b0; i_EXMEM_clear = 1'b0;
        i_id_rdwren = 1'b1; i_id_is_br = 1'b0; i_id_is_uncbr = 1'b0; i_ex_pcsel = 1'b0;
        i_pc_next = m_pc + 32'd4;
        i_instr = $urandom;
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge i_clk) begin
        if (chk_en) begin
            logic [31:0] ins;
            ins = m[0].instr;
            chk("pc",          o_pc,                   m_pc);
            chk("ifid_pc",     o_IFID_pc,              m[0].pc);
            chk("ifid_instr",  o_IFID_instr,           m[0].instr);
            chk("ifid_rs1",    32'(o_IFID_rs1),        32'(ins[19:15]));
            chk("ifid_rs2",    32'(o_IFID_rs2),        32'(ins[24:20]));
            chk("idex_ctl",    {28'h0, o_IDEX_valid, o_IDEX_rdwren, o_IDEX_is_br, o_IDEX_is_uncbr},
                               {28'h0, m[1].valid, m[1].rdwren, m[1].is_br, m[1].is_uncbr});
            chk("idex_rd",     32'(o_IDEX_rd),         32'(m[1].rd));
            chk("exmem_ctl",   {27'h0, o_EXMEM_valid, o_EXMEM_rdwren, o_EXMEM_pcsel, o_EXMEM_is_br, o_EXMEM_is_uncbr},
                               {27'h0, m[2].valid, m[2].rdwren, m[2].pcsel, m[2].is_br, m[2].is_uncbr});
            chk("exmem_rd",    32'(o_EXMEM_rd),        32'(m[2].rd));
            chk("memwb_ctl",   {30'h0, o_MEMWB_valid, o_MEMWB_rdwren}, {30'h0, m[3].valid, m[3].rdwren});
            chk("memwb_rd",    32'(o_MEMWB_rd),        32'(m[3].rd));
            chk("stall_cnt",   32'(o_stall_cnt),       32'(m_stall));
            chk("flush_cnt",   32'(o_flush_cnt),       32'(m_flush));
            chk("retire_cnt",  32'(o_retire_cnt),      32'(m_retire));
        end
    end

    initial begin
        logic [31:0] held_instr;
        for (int i = 0; i < 4; i++) m[i] = bubble();
        m_pc = '0; m_stall = 0; m_flush = 0; m_retire = 0;
        run_defaults();
        i_rst = 1'b1;

        // Reset
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_pc",       o_pc,                     32'h0000_0100);
        chk("rst_instr",    o_IFID_instr,             32'h0000_0013);
        chk("rst_valids",   {29'h0, o_IDEX_valid, o_EXMEM_valid, o_MEMWB_valid}, 32'h0);
        chk("rst_cnts",     {20'h0, o_stall_cnt, o_flush_cnt, o_retire_cnt}, 32'h0);

        // Straight-line flow
        for (int k = 1; k <= 8; k++) begin
            run_defaults();
            i_instr = {$urandom} | 32'h0000_0080;
            held_instr = i_instr;
            tick();
            if (k == 1) chk("sl_ifid_pc",  o_IFID_pc, 32'h0000_0100);
            if (k == 3) chk("sl_wb_early", 32'(o_MEMWB_valid), 32'h0);
            if (k == 4) chk("sl_wb_valid", 32'(o_MEMWB_valid), 32'h1);
            if (k == 4) chk("sl_ret0",     32'(o_retire_cnt),  32'h0);
            if (k == 5) chk("sl_ret1",     32'(o_retire_cnt),  32'h1);
            if (k == 6) chk("sl_ret2",     32'(o_retire_cnt),  32'h2);
        end

        // RAW stall for two cycles
        for (int k = 0; k < 2; k++) begin
            run_defaults();
            i_pc_wren = 1'b0; i_IFID_wren = 1'b0; i_IDEX_clear = 1'b1;
            i_pc_next = 32'h0000_0DEC;
            tick();
            chk("stall_idex_bub", {30'h0, o_IDEX_valid, o_IDEX_rdwren}, 32'h0);
        end
        chk("stall_pc",    o_pc,                32'h0000_0120);
        chk("stall_instr", o_IFID_instr,        held_instr);
        chk("stall_cnt2",  32'(o_stall_cnt),    32'h2);

        // Branch decoded, then resolved taken in EX, then flushed
        run_defaults(); i_id_is_br = 1'b1;
        tick();
        chk("br_idex_isbr", 32'(o_IDEX_is_br), 32'h1);
        run_defaults(); i_ex_pcsel = 1'b1;
        tick();
        chk("br_exmem", {30'h0, o_EXMEM_pcsel, o_EXMEM_is_br}, 32'h3);
        run_defaults();
        i_IFID_clear = 1'b1; i_IDEX_clear = 1'b1; i_EXMEM_clear = 1'b1;
        i_pc_next = 32'h0000_0200;
        tick();
        chk("fl_pc",      o_pc,          32'h0000_0200);
        chk("fl_instr",   o_IFID_instr,  32'h0000_0013);
        chk("fl_bubbles", {29'h0, o_IDEX_valid, o_EXMEM_valid, o_EXMEM_pcsel}, 32'h0);
        chk("fl_cnt",     32'(o_flush_cnt), 32'h1);

        // Clear wins over wren in IF/ID
        run_defaults();
        i_IFID_clear = 1'b1; i_instr = 32'hDEAD_BEEF;
        tick();
        chk("cw_instr", o_IFID_instr, 32'h0000_0013);

        // Stall counter saturation
        for (int k = 0; k < 20; k++) begin
            run_defaults();
            i_pc_wren = 1'b0; i_IFID_wren = 1'b0; i_IDEX_clear = 1'b1;
            tick();
        end
        chk("sat_stall", 32'(o_stall_cnt), 32'h0000_000F);

        // Reset during a flush
        run_defaults();
        i_rst = 1'b1;
        i_IFID_clear = 1'b1; i_IDEX_clear = 1'b1; i_EXMEM_clear = 1'b1;
        i_pc_next = 32'h0000_0200;
        tick();
        chk("rf_pc",    o_pc,         32'h0000_0100);
        chk("rf_instr", o_IFID_instr, 32'h0000_0013);
        chk("rf_cnts",  {20'h0, o_stall_cnt, o_flush_cnt, o_retire_cnt}, 32'h0);

        // Randomized controls
        for (int k = 0; k < 3000; k++) begin
            i_rst         = ($urandom_range(0, 63) == 0);
            i_pc_wren     = ($urandom_range(0, 3) != 0);
            i_IFID_wren   = ($urandom_range(0, 3) != 0);
            i_IFID_clear  = ($urandom_range(0, 5) == 0);
            i_IDEX_clear  = ($urandom_range(0, 5) == 0);
            i_EXMEM_clear = ($urandom_range(0, 7) == 0);
            i_pc_next     = {$urandom} & 32'hFFFF_FFFC;
            i_instr       = $urandom;
            i_id_rdwren   = 1'($urandom_range(0, 1));
            i_id_is_br    = 1'($urandom_range(0, 1));
            i_id_is_uncbr = 1'($urandom_range(0, 1));
            i_ex_pcsel    = 1'($urandom_range(0, 1));
            tick();
        end

        @(negedge i_clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
